// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data RAM: stage 3 load/store versus the debug/loader port.
// Optional Stall_count/Stats_clr statistics are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Pipe_req,
  input  logic              Pipe_we,
  input  logic [ADDR_W-1:0] Pipe_addr,
  input  logic [DATA_W-1:0] Pipe_wdata,
  output logic              Pipe_stall,
  output logic [DATA_W-1:0] Pipe_rdata,
  input  logic              Dbg_req,
  input  logic              Dbg_we,
  input  logic              Dbg_lock,
  input  logic [ADDR_W-1:0] Dbg_addr,
  input  logic [DATA_W-1:0] Dbg_wdata,
  output logic              Dbg_gnt,
  output logic [DATA_W-1:0] Dbg_rdata,
  output logic              Dbg_rvalid,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] Mem_din,
  input  logic [DATA_W-1:0] Mem_dout
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              Stats_clr,
  output logic [15:0]       Stall_count
`endif
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam int LC_W = $clog2(LOCK_MAX + 1);

  // DBG names the single-access grant cycle; the register itself stays in PIPE.
  typedef enum logic [1:0] {PIPE, DBG, LOCK, REL} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [LC_W-1:0]   lock_q, lock_d;
  logic              rd_dbg_q, rd_dbg_d;
  logic              dbg_gnt, pipe_own, wait_full;

  assign wait_full = (wait_q == WC_W'(MAX_WAIT));

  always_comb begin
    dbg_gnt  = 1'b0;
    pipe_own = 1'b1;
    if (!Rst) begin
      unique case (state_q)
        LOCK: begin
          dbg_gnt  = Dbg_req;
          pipe_own = 1'b0;
        end
        REL: begin
          dbg_gnt  = 1'b0;
          pipe_own = 1'b1;
        end
        default: begin
          dbg_gnt  = Dbg_req & (~Pipe_req | wait_full);
          pipe_own = ~dbg_gnt;
        end
      endcase
    end
  end

  assign Dbg_gnt    = dbg_gnt;
  assign Pipe_stall = Pipe_req & ~pipe_own & ~Rst;

  always_comb begin
    if (dbg_gnt) begin
      Mem_we   = Dbg_we & Dbg_req;
      Mem_addr = Dbg_addr;
      Mem_din  = Dbg_wdata;
    end else begin
      Mem_we   = Pipe_we & Pipe_req & pipe_own & ~Rst;
      Mem_addr = Pipe_addr;
      Mem_din  = Pipe_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = '0;
    unique case (state_q)
      LOCK: begin
        if (!Dbg_lock) begin
          state_d = PIPE;
        end else if (lock_q == LC_W'(LOCK_MAX - 1)) begin
          state_d = REL;
        end else begin
          lock_d = lock_q + LC_W'(1);
        end
      end
      REL: state_d = Dbg_lock ? LOCK : PIPE;
      default: begin
        // The grant cycle in PIPE is the first debug-owned cycle of a burst.
        if (dbg_gnt && Dbg_lock) begin
          state_d = LOCK;
          lock_d  = LC_W'(1);
        end else begin
          state_d = PIPE;
        end
      end
    endcase

    if (!Dbg_req || dbg_gnt)  wait_d = '0;
    else if (!wait_full)      wait_d = wait_q + WC_W'(1);
    else                      wait_d = wait_q;

    rd_dbg_d = dbg_gnt & ~Dbg_we;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= PIPE;
      wait_q   <= '0;
      lock_q   <= '0;
      rd_dbg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      lock_q   <= lock_d;
      rd_dbg_q <= rd_dbg_d;
    end
  end

  assign Dbg_rvalid = rd_dbg_q;
  assign Dbg_rdata  = rd_dbg_q ? Mem_dout : '0;
  assign Pipe_rdata = Mem_dout;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst || Stats_clr)                       stall_cnt_q <= '0;
    else if (Pipe_stall && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign Stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data RAM between the pipeline's stage 3 (load/store) and a debug/loader port (UART monitor, program loader).
- Sits between stage 3 and the RAM instance and owns all RAM control inputs.
- Pipeline has priority by default.
- Debug requests are guaranteed service through a starvation counter; debug may lock the RAM for bursts.
- When the pipeline loses the RAM, the block stalls it.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
MAX_WAIT, 4, consecutive cycles a pending debug request may be refused before it pre-empts the pipeline (>=1)
LOCK_MAX, 16, max consecutive debug-owned cycles in a locked burst before a forced one-cycle release (>=2)

Ports:
Clk  in  1  clock
Rst  in  1  synchronous reset, active-high
Pipe_req  in  1  stage 3 needs RAM this cycle (LOAD or store opcode)
Pipe_we  in  1  stage 3 write enable
Pipe_addr  in  ADDR_W  stage 3 address
Pipe_wdata  in  DATA_W  stage 3 write data
Pipe_stall  out  1  pipeline must hold stage 3 this cycle
Pipe_rdata  out  DATA_W  read data to stage 3
Dbg_req  in  1  debug access request, held until granted
Dbg_we  in  1  debug write enable
Dbg_lock  in  1  keep ownership after this access (burst)
Dbg_addr  in  ADDR_W  debug address
Dbg_wdata  in  DATA_W  debug write data
Dbg_gnt  out  1  debug access accepted this cycle
Dbg_rdata  out  DATA_W  debug read data
Dbg_rvalid  out  1  Dbg_rdata valid
Mem_we  out  1  RAM We
Mem_addr  out  ADDR_W  RAM Addr
Mem_din  out  DATA_W  RAM Data_in
Mem_dout  in  DATA_W  RAM Data_out

Behaviour:
- FSM states: PIPE (default owner), DBG (single debug access), LOCK (debug burst), REL (forced release). The state register resets to PIPE.
- Starve counter `wait_cnt`, 0..MAX_WAIT, saturating:
  - Increments on cycles where Dbg_req=1 and Dbg_gnt=0.
  - Clears on Dbg_gnt or when Dbg_req=0.
- Burst counter `lock_cnt`, 0..LOCK_MAX:
  - Counts debug-owned cycles in LOCK.
  - Clears on leaving LOCK.
- Grant rule (combinational from state and counters):
  - PIPE: debug granted if Dbg_req & (~Pipe_req | wait_cnt==MAX_WAIT); otherwise the pipeline owns the RAM.
  - LOCK: debug granted whenever Dbg_req=1. Pipe_stall=Pipe_req. Idle debug cycles inside LOCK still belong to debug.
  - REL: debug never granted; the pipeline owns the RAM.
- Transitions:
  - PIPE -> LOCK on a grant with Dbg_lock=1.
  - PIPE stays on a grant with Dbg_lock=0. DBG is a transient label for that cycle only.
  - LOCK -> PIPE on a granted access with Dbg_lock=0.
  - LOCK -> PIPE if Dbg_req=0 and Dbg_lock=0.
  - LOCK -> REL when lock_cnt reaches LOCK_MAX-1 while still locked.
  - REL -> LOCK next cycle if Dbg_lock is still 1; else REL -> PIPE.
- Pipe_stall = Pipe_req & ~(pipeline owns the RAM this cycle). Purely combinational, same cycle.
- Mem_* driven combinationally from the winning requester.
  - Mem_we = winner_we & winner_req.
  - Mem_we = 0 when there is no winner.
- Read latency is 1 cycle (RAM Data_out registered).
  - A registered owner tag records who issued the read.
  - Dbg_rvalid=1 the cycle after a granted debug read (Dbg_we=0); Dbg_rdata=Mem_dout then.
  - Pipe_rdata=Mem_dout always. Stage 3 consumes it only after an unstalled LOAD.
- Simultaneous requests at equal priority: the pipeline wins unless wait_cnt==MAX_WAIT.
- Debug writes complete in the grant cycle. Debug reads never produce Dbg_rvalid for writes.
- Reset (any cycle, mid-burst included), effective on the next clock edge:
  - State=PIPE, wait_cnt=0, lock_cnt=0.
  - Dbg_rvalid=0; a pending read response is dropped.
  - While Rst=1: Mem_we=0, Dbg_gnt=0, Pipe_stall=0.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds output Stall_count [15:0], a saturating count of cycles with Pipe_stall=1, cleared by Rst. Also adds input Stats_clr, which clears it synchronously; Stats_clr has priority over increment.
- Undefined: ports absent, no counter logic.

Test Plan:
- Rst=1 for 2 cycles, then idle -> all outputs 0, Mem_we=0, state PIPE.
- Pipe_req=1 continuously and Dbg_req=1 read addr 0x10 (RAM[0x10]=0xA5), MAX_WAIT=4:
  - Dbg_gnt=0 for 4 cycles.
  - Grant in cycle 5 with Pipe_stall=1 that cycle only.
  - Dbg_rvalid=1, Dbg_rdata=0xA5 in cycle 6.
- Pipe_req=0, debug write 0x3C to addr 0x20 -> Dbg_gnt same cycle, Mem_we=1. A later pipeline LOAD 0x20 returns 0x3C with no stall.
- Dbg_lock=1 burst of 20 writes, LOCK_MAX=16, Pipe_req=1:
  - Pipe_stall=1 for 16 cycles, then exactly one cycle with Pipe_stall=0 and Dbg_gnt=0 (REL).
  - Burst then resumes and completes; all 20 addresses are written.
- Rst asserted mid-LOCK with a debug read outstanding -> next cycle Dbg_rvalid=0 and Pipe_stall=0; the pipeline owns the RAM.
- With DMEM_ARB_STATS_EN: 5 pre-empted cycles give Stall_count=5; Stats_clr gives 0.
